// File: rtl/rvv_lane_scheduler.sv
// rvv_lane_scheduler: walks the element groups of one vector instruction across the lanes.
// Latency: the first beat is presented the cycle after start; then one beat or one skipped group per cycle.
// Backpressure: while issue_ready is low the presented beat and every issue output hold unchanged.
module rvv_lane_scheduler #(
  parameter int VLEN            = 128,
  parameter int LANE_WIDTH_LOG2 = 3,
  parameter int NB_LANES_LOG2   = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              vm,
  input  logic [VLEN-1:0]                   v0_mask,
  input  logic [2:0]                        vsew,
  input  logic [10:0]                       vl,
  input  logic [10:0]                       vstart,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [(1<<NB_LANES_LOG2)-1:0]     lane_en,
  output logic [11*(1<<NB_LANES_LOG2)-1:0]  lane_idx,
  output logic [3:0]                        chunk,
  output logic                              chunk_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);
  localparam int NL  = 1 << NB_LANES_LOG2;
  localparam int VIW = $clog2(VLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      base_q, base_d, base_inc;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cmax_q, cmax_d;
  logic [10:0]      end_q, end_d;
  logic             vm_q, vm_d;
  logic             rsv_q, rsv_d;
  logic [VLEN-1:0]  mask_q, mask_d;

  logic             in_rsv;
  logic [3:0]       sew_log2, shamt;
  logic [10:0]      vlmax, in_end;
  logic [3:0]       in_cmax;

  logic [NL-1:0]    grp_en;
  logic [11*NL-1:0] grp_idx;
  logic [11:0]      lane_pos;
  logic             beat_d;

  // Decode the effective end index and the last chunk number from the raw start inputs.
  always_comb begin
    in_rsv   = (vsew > 3'd3);
    sew_log2 = {1'b0, vsew} + 4'd3;
    vlmax    = 11'(VLEN) >> sew_log2;
    in_end   = '0;
    in_cmax  = '0;
    shamt    = '0;
    if (!in_rsv) begin
      in_end = (vl < vlmax) ? vl : vlmax;
      if (sew_log2 > 4'(LANE_WIDTH_LOG2)) begin
        shamt = sew_log2 - 4'(LANE_WIDTH_LOG2);
      end
      in_cmax = 4'((8'd1 << shamt) - 8'd1);
    end
  end

  // Next state: latch on start, advance chunk/group on accept, skip masked groups, stop at end.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    cmax_d   = cmax_q;
    end_d    = end_q;
    vm_d     = vm_q;
    rsv_d    = rsv_q;
    mask_d   = mask_q;
    base_inc = base_q + 12'(NL);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          base_d  = {1'b0, vstart};
          cnt_d   = '0;
          cmax_d  = in_cmax;
          end_d   = in_end;
          vm_d    = vm;
          rsv_d   = in_rsv;
          mask_d  = v0_mask;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (base_q >= {1'b0, end_q}) begin
          // Nothing to issue at all (empty range or reserved width).
          state_d = DONE;
        end else if (issue_valid) begin
          if (issue_ready) begin
            if (cnt_q < cmax_q) begin
              cnt_d = cnt_q + 4'd1;
            end else begin
              cnt_d  = '0;
              base_d = base_inc;
              if (base_inc >= {1'b0, end_q}) state_d = DONE;
            end
          end
        end else begin
          // Fully masked group: spend one idle cycle and drop all its chunks.
          cnt_d  = '0;
          base_d = base_inc;
          if (base_inc >= {1'b0, end_q}) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-lane indices and enables of the group that will be presented in the next cycle.
  always_comb begin
    grp_en   = '0;
    grp_idx  = '0;
    lane_pos = '0;
    for (int i = 0; i < NL; i++) begin
      lane_pos = base_d + 12'(i);
      if (lane_pos < {1'b0, end_d}) begin
        grp_idx[i*11 +: 11] = lane_pos[10:0];
        grp_en[i]           = vm_d | mask_d[lane_pos[VIW-1:0]];
      end
    end
  end

  assign beat_d = (state_d == ISSUE) && (|grp_en);

  // State, latched instruction fields and the registered issue outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      cmax_q      <= '0;
      end_q       <= '0;
      vm_q        <= 1'b0;
      rsv_q       <= 1'b0;
      mask_q      <= '0;
      issue_valid <= 1'b0;
      lane_en     <= '0;
      lane_idx    <= '0;
      chunk       <= '0;
      chunk_last  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      cmax_q      <= cmax_d;
      end_q       <= end_d;
      vm_q        <= vm_d;
      rsv_q       <= rsv_d;
      mask_q      <= mask_d;
      issue_valid <= beat_d;
      lane_en     <= beat_d ? grp_en : '0;
      lane_idx    <= beat_d ? grp_idx : '0;
      chunk       <= beat_d ? cnt_d : '0;
      chunk_last  <= beat_d && (cnt_d == cmax_d);
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = (state_q == DONE) && rsv_q;

endmodule

// File: tb/tb_rvv_lane_scheduler.sv
// tb_rvv_lane_scheduler: scenario tasks plus randomized instructions against an element-list model.
// Latency: model predicts the done cycle from the group list and the ready pattern.
// Backpressure: ready is driven from a per-cycle pattern shared by the model and the driver.
module tb_rvv_lane_scheduler;
  localparam int VLEN   = 128;
  localparam int LW2    = 3;
  localparam int NB     = 1;
  localparam int NL     = 1 << NB;
  localparam int LANE_W = 1 << LW2;
  localparam int MAXCYC = 600;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              vm = 1'b1;
  logic [VLEN-1:0]   v0_mask = '0;
  logic [2:0]        vsew = '0;
  logic [10:0]       vl = '0;
  logic [10:0]       vstart = '0;
  logic              issue_ready = 1'b0;
  logic              issue_valid;
  logic [NL-1:0]     lane_en;
  logic [11*NL-1:0]  lane_idx;
  logic [3:0]        chunk;
  logic              chunk_last;
  logic              busy, done, err;

  always #5 clk = ~clk;

  rvv_lane_scheduler #(.VLEN(VLEN), .LANE_WIDTH_LOG2(LW2), .NB_LANES_LOG2(NB)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .vm(vm), .v0_mask(v0_mask),
    .vsew(vsew), .vl(vl), .vstart(vstart), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .lane_en(lane_en), .lane_idx(lane_idx), .chunk(chunk), .chunk_last(chunk_last),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [11*NL-1:0] idx;
    logic [NL-1:0]    en;
    logic [3:0]       chunk;
    logic             last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  logic  ready_pat [0:1023];

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    exp_done_cyc, obs_done_cyc, obs_done_cnt, obs_idle_cyc, obs_unstable, obs_valid_cnt;
  logic  exp_err, obs_err, obs_valid_at_idle;

  task automatic fill_ready(input int pct);
    for (int k = 0; k < 1024; k++) ready_pat[k] = ($urandom_range(0, 99) < pct);
  endtask

  // Reference: enumerate groups from vstart in steps of the lane count up to min(vl, VLMAX).
  task automatic build_model(input logic m_vm, input logic [VLEN-1:0] m_mask,
                             input int m_vsew, input int m_vl, input int m_vstart);
    int    sew, vlmax, endv, nchunk, cyc;
    int    kinds[$];
    beat_t bt;
    exp_q.delete();
    exp_err = (m_vsew > 3);
    endv    = 0;
    nchunk  = 1;
    if (!exp_err) begin
      sew    = 8 << m_vsew;
      vlmax  = VLEN / sew;
      endv   = (m_vl < vlmax) ? m_vl : vlmax;
      nchunk = (sew > LANE_W) ? sew / LANE_W : 1;
    end
    for (int b = m_vstart; b < endv; b += NL) begin
      bt = '0;
      for (int i = 0; i < NL; i++) begin
        if (b + i < endv) begin
          bt.idx[i*11 +: 11] = 11'(b + i);
          bt.en[i]           = m_vm | m_mask[b + i];
        end
      end
      if (bt.en == '0) kinds.push_back(0);
      else begin
        for (int c = 0; c < nchunk; c++) begin
          bt.chunk = 4'(c);
          bt.last  = (c == nchunk - 1);
          exp_q.push_back(bt);
          kinds.push_back(1);
        end
      end
    end
    if (kinds.size() == 0) kinds.push_back(0);
    cyc = 1;
    foreach (kinds[k]) begin
      if (kinds[k] == 1) while (!ready_pat[cyc] && cyc < MAXCYC) cyc++;
      cyc++;
    end
    exp_done_cyc = cyc;
  endtask

  // Drives one instruction (start in cycle 0) and records what the lanes observe.
  task automatic run_instr(input logic r_vm, input logic [VLEN-1:0] r_mask, input int r_vsew,
                           input int r_vl, input int r_vstart, input int r_abort_cyc);
    beat_t cur, prev;
    logic  prev_stall;
    obs_q.delete();
    obs_done_cyc = -1; obs_done_cnt = 0; obs_idle_cyc = -1; obs_unstable = 0;
    obs_valid_cnt = 0; obs_err = 1'b0; obs_valid_at_idle = 1'b0;
    vm = r_vm; v0_mask = r_mask; vsew = 3'(r_vsew); vl = 11'(r_vl); vstart = 11'(r_vstart);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = '0;
    prev_stall = 1'b0;
    for (int cyc = 1; cyc < MAXCYC; cyc++) begin
      issue_ready = ready_pat[cyc];
      abort       = (cyc == r_abort_cyc);
      cur.idx = lane_idx; cur.en = lane_en; cur.chunk = chunk; cur.last = chunk_last;
      if (prev_stall && (cur !== prev || !issue_valid)) obs_unstable++;
      prev       = cur;
      prev_stall = issue_valid && !issue_ready;
      if (issue_valid) obs_valid_cnt++;
      if (issue_valid && issue_ready) obs_q.push_back(cur);
      if (done) begin obs_done_cnt++; obs_done_cyc = cyc; obs_err = err; end
      if (!busy) begin obs_idle_cyc = cyc; obs_valid_at_idle = issue_valid; break; end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    issue_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    checks++; if (lane_en !== '0) begin errors++; $display("FAIL reset_lane_en: got %b want 0", lane_en); end
    checks++; if (lane_idx !== '0) begin errors++; $display("FAIL reset_lane_idx: got %h want 0", lane_idx); end
    checks++; if (chunk !== 4'd0) begin errors++; $display("FAIL reset_chunk: got %0d want 0", chunk); end
    checks++; if (chunk_last !== 1'b0) begin errors++; $display("FAIL reset_chunk_last: got %b want 0", chunk_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plain();
    beat_t lit;
    fill_ready(100);
    build_model(1'b1, '0, 0, 5, 0);
    run_instr(1'b1, '0, 0, 5, 0, -1);
    checks++; if (obs_idle_cyc < 0) begin errors++; $display("FAIL plain_timeout: never returned idle within %0d cycles", MAXCYC); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL plain_beats: got %0d want 3", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL plain_beat%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
      end
    end
    lit.idx = {11'd0, 11'd4}; lit.en = 2'b01; lit.chunk = 4'd0; lit.last = 1'b1;
    checks++; if (obs_q.size() < 3 || obs_q[2] !== lit) begin errors++; $display("FAIL plain_last_beat: got %h want %h", (obs_q.size() >= 3) ? obs_q[2] : '1, lit); end
    checks++; if (obs_done_cyc != 4) begin errors++; $display("FAIL plain_done_cycle: got %0d want 4", obs_done_cyc); end
    checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL plain_done_count: got %0d want 1", obs_done_cnt); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL plain_err: got %b want 0", obs_err); end
  endtask

  task automatic test_chunking();
    beat_t lit;
    int    nlast;
    fill_ready(100);
    build_model(1'b1, '0, 2, 3, 0);
    run_instr(1'b1, '0, 2, 3, 0, -1);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL chunk_beats: got %0d want 8", obs_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL chunk_beat%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
      end
    end
    lit.idx = {11'd0, 11'd2}; lit.en = 2'b01; lit.chunk = 4'd0; lit.last = 1'b0;
    checks++; if (obs_q.size() < 5 || obs_q[4] !== lit) begin errors++; $display("FAIL chunk_group2_first: got %h want %h", (obs_q.size() >= 5) ? obs_q[4] : '1, lit); end
    nlast = 0;
    foreach (obs_q[k]) if (obs_q[k].last) nlast++;
    checks++; if (nlast != 2) begin errors++; $display("FAIL chunk_last_count: got %0d want 2", nlast); end
    checks++; if (obs_done_cyc != exp_done_cyc) begin errors++; $display("FAIL chunk_done_cycle: got %0d want %0d", obs_done_cyc, exp_done_cyc); end
  endtask

  task automatic test_backpressure();
    beat_t lit;
    fill_ready(100);
    ready_pat[2] = 1'b0; ready_pat[3] = 1'b0; ready_pat[4] = 1'b0;
    build_model(1'b1, '0, 0, 5, 0);
    run_instr(1'b1, '0, 0, 5, 0, -1);
    checks++; if (obs_unstable != 0) begin errors++; $display("FAIL bp_hold: %0d stalled cycles changed outputs, want 0", obs_unstable); end
    lit.idx = {11'd3, 11'd2}; lit.en = 2'b11; lit.chunk = 4'd0; lit.last = 1'b1;
    checks++; if (obs_q.size() < 2 || obs_q[1] !== lit) begin errors++; $display("FAIL bp_frozen_beat: got %h want %h", (obs_q.size() >= 2) ? obs_q[1] : '1, lit); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_beat%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
      end
    end
    checks++; if (obs_valid_cnt != 6) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 6", obs_valid_cnt); end
    checks++; if (obs_done_cyc != 7) begin errors++; $display("FAIL bp_done_cycle: got %0d want 7", obs_done_cyc); end
  endtask

  task automatic test_mask_skip();
    beat_t           lit;
    logic [VLEN-1:0] m;
    m = '0; m[3:2] = 2'b11;
    fill_ready(100);
    build_model(1'b0, m, 0, 8, 0);
    run_instr(1'b0, m, 0, 8, 0, -1);
    lit.idx = {11'd3, 11'd2}; lit.en = 2'b11; lit.chunk = 4'd0; lit.last = 1'b1;
    checks++; if (obs_valid_cnt != 1) begin errors++; $display("FAIL mask_valid_cycles: got %0d want 1", obs_valid_cnt); end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== lit) begin errors++; $display("FAIL mask_beat: got %0d beats, first %h want %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '1, lit); end
    checks++; if (obs_done_cyc != exp_done_cyc) begin errors++; $display("FAIL mask_done_cycle: got %0d want %0d", obs_done_cyc, exp_done_cyc); end
    checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL mask_done_count: got %0d want 1", obs_done_cnt); end
  endtask

  task automatic test_bounds();
    int vsew_t[4]   = '{0, 0, 0, 4};
    int vl_t[4]     = '{200, 5, 0, 5};
    int vstart_t[4] = '{0, 3, 0, 0};
    int nbeat_t[4]  = '{8, 1, 0, 0};
    int done_t[4]   = '{9, 2, 2, 2};
    int err_t[4]    = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      fill_ready(100);
      build_model(1'b1, '0, vsew_t[t], vl_t[t], vstart_t[t]);
      run_instr(1'b1, '0, vsew_t[t], vl_t[t], vstart_t[t], -1);
      checks++; if (obs_valid_cnt != nbeat_t[t]) begin errors++; $display("FAIL bounds%0d_valid_cycles: got %0d want %0d", t, obs_valid_cnt, nbeat_t[t]); end
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL bounds%0d_beat%0d: got %h want %h", t, k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
        end
      end
      checks++; if (obs_done_cyc != done_t[t]) begin errors++; $display("FAIL bounds%0d_done_cycle: got %0d want %0d", t, obs_done_cyc, done_t[t]); end
      checks++; if (obs_err !== err_t[t][0]) begin errors++; $display("FAIL bounds%0d_err: got %b want %0d", t, obs_err, err_t[t]); end
      if (t == 0) begin
        checks++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].idx !== {11'd15, 11'd14}) begin errors++; $display("FAIL bounds0_top_idx: got %0d beats, want last idx (14,15)", obs_q.size()); end
      end
    end
  endtask

  task automatic test_abort();
    fill_ready(100);
    run_instr(1'b1, '0, 0, 16, 0, 2);
    checks++; if (obs_idle_cyc != 3) begin errors++; $display("FAIL abort_idle_cycle: got %0d want 3", obs_idle_cyc); end
    checks++; if (obs_valid_at_idle !== 1'b0) begin errors++; $display("FAIL abort_valid_drop: got %b want 0", obs_valid_at_idle); end
    checks++; if (obs_done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", obs_done_cnt); end
    build_model(1'b1, '0, 0, 5, 0);
    run_instr(1'b1, '0, 0, 5, 0, -1);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_restart_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL abort_restart_beat%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
      end
    end
    checks++; if (obs_done_cyc != exp_done_cyc) begin errors++; $display("FAIL abort_restart_done: got %0d want %0d", obs_done_cyc, exp_done_cyc); end
  endtask

  task automatic test_reset_mid();
    vm = 1'b1; v0_mask = '0; vsew = 3'd0; vl = 11'd16; vstart = 11'd0; issue_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL rstmid_presenting: got %b want 1", issue_valid); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if ({issue_valid, lane_en, lane_idx, chunk, chunk_last} !== '0) begin errors++; $display("FAIL rstmid_issue_outputs: got %b/%b/%h/%0d/%b want all 0", issue_valid, lane_en, lane_idx, chunk, chunk_last); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rstmid_status: got %b want 000", {busy, done, err}); end
    resetn = 1'b1;
    @(posedge clk); #1;
    fill_ready(100);
    run_instr(1'b1, '0, 0, 5, 0, -1);
    checks++; if (obs_q.size() != 3 || obs_done_cyc != 4) begin errors++; $display("FAIL rstmid_rerun: got %0d beats done at %0d want 3 beats done at 4", obs_q.size(), obs_done_cyc); end
  endtask

  task automatic test_random();
    logic [VLEN-1:0] m;
    logic            rvm;
    int              rsew, rvl, rvs;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < VLEN; w += 32) m[w +: 32] = $urandom;
      rvm  = 1'($urandom_range(0, 1));
      rsew = ($urandom_range(0, 9) == 0) ? 4 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      rvl  = $urandom_range(0, 40);
      rvs  = $urandom_range(0, 20);
      fill_ready(60);
      build_model(rvm, m, rsew, rvl, rvs);
      run_instr(rvm, m, rsew, rvl, rvs, -1);
      checks++; if (obs_idle_cyc < 0) begin errors++; $display("FAIL rand%0d_timeout: never returned idle", it); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_beats: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]);
        end
      end
      checks++; if (obs_done_cyc != exp_done_cyc) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, obs_done_cyc, exp_done_cyc); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %b want %b", it, obs_err, exp_err); end
      checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d want 1", it, obs_done_cnt); end
      checks++; if (obs_unstable != 0) begin errors++; $display("FAIL rand%0d_hold: %0d stalled cycles changed outputs", it, obs_unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_chunking();
    test_backpressure();
    test_mask_skip();
    test_bounds();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
